// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU): one restoring trial subtraction per cycle.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish in one cycle.
module div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] data_out
);

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_CALC, S_FIN} state_t;

    state_t            state_q, state_d;
    logic              op_rem_q, op_rem_d;
    logic              signed_q, signed_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   q_q, q_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   data_out_q, data_out_d;

    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     trial;

    function automatic logic [XLEN-1:0] abs_val(input logic signed [XLEN-1:0] v);
        return v[XLEN-1] ? XLEN'(-v) : XLEN'(v);
    endfunction

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? XLEN'(-v) : v;
    endfunction

    // The shifted partial remainder is 33 bits; the stored remainder never exceeds 32.
    assign rem_sh = {rem_q, q_q[XLEN-1]};
    assign trial  = rem_sh + {1'b1, ~dvs_q} + (XLEN+1)'(1);

    always_comb begin
        state_d    = state_q;
        op_rem_d   = op_rem_q;
        signed_d   = signed_q;
        a_d        = a_q;
        b_d        = b_q;
        q_d        = q_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        data_out_d = data_out_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_rem_d = op[1];
                    signed_d = ~op[0];
                    a_d      = rs1;
                    b_d      = rs2;
                    state_d  = S_PREP;
`ifdef DIV_EARLY_OUT_EN
                    if (rs2 == '0) begin
                        q_d       = '1;
                        rem_d     = rs1;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = S_FIN;
                    end else if (!op[0] && rs1 == {1'b1, {(XLEN-1){1'b0}}} && rs2 == '1) begin
                        q_d       = {1'b1, {(XLEN-1){1'b0}}};
                        rem_d     = '0;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = S_FIN;
                    end
`endif
                end
            end
            S_PREP: begin
                q_d       = signed_q ? abs_val(a_q) : a_q;
                dvs_d     = signed_q ? abs_val(b_q) : b_q;
                // Divide-by-zero keeps the all-ones quotient unsigned.
                neg_quo_d = signed_q & (a_q[XLEN-1] ^ b_q[XLEN-1]) & (b_q != '0);
                neg_rem_d = signed_q & a_q[XLEN-1];
                rem_d     = '0;
                cnt_d     = '0;
                state_d   = S_CALC;
            end
            S_CALC: begin
                q_d   = {q_q[XLEN-2:0], ~trial[XLEN]};
                rem_d = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN-1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                data_out_d = op_rem_q ? cond_neg(rem_q, neg_rem_q) : cond_neg(q_q, neg_quo_q);
                done_d     = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_rem_q   <= 1'b0;
            signed_q   <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            q_q        <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            op_rem_q   <= op_rem_d;
            signed_q   <= signed_d;
            a_q        <= a_d;
            b_q        <= b_d;
            q_q        <= q_d;
            rem_q      <= rem_d;
            dvs_q      <= dvs_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            data_out_q <= data_out_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign data_out = data_out_q;

endmodule
